// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch stage with a 2-entry prefetch queue.
//
// Drives the program ROM address from the fetch PC. It captures the word the
// ROM returns, together with its address, into a two-deep FIFO. The FIFO head
// is offered downstream through a valid/ready handshake. A redirect flushes
// the queue and restarts fetch at the jump target.
//
// Ports:
//   clock        rising-edge clock
//   resetn       asynchronous active-low reset
//   rom_addr     ROM address (the fetch PC register)
//   rom_data     combinational ROM word for rom_addr
//   ir           head instruction, zero when the queue is empty
//   ir_pc        head instruction address, zero when the queue is empty
//   ir_valid     queue is not empty
//   ir_ready     downstream consumes the head this cycle
//   redirect     jump taken: flush and refetch from redirect_pc
//   redirect_pc  jump target
//   stall_count  (FETCH_STALLCNT_EN only) saturating count of cycles with
//                ir_valid high and ir_ready low
//
// Optional feature macro: FETCH_STALLCNT_EN
module fetch_queue #(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned INSTR_W  = 35,
    parameter int unsigned PC_STEP  = 4,
    parameter int unsigned RESET_PC = 0
) (
    input  logic               clock,
    input  logic               resetn,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [INSTR_W-1:0] rom_data,
    output logic [INSTR_W-1:0] ir,
    output logic [ADDR_W-1:0]  ir_pc,
    output logic               ir_valid,
    input  logic               ir_ready,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc
`ifdef FETCH_STALLCNT_EN
    ,
    output logic [15:0]        stall_count
`endif
);

    // Shift-style FIFO: slot 0 is always the head. Empty slots hold zeros,
    // so the head registers drive ir/ir_pc directly and read as NOP when empty.
    logic [INSTR_W-1:0] e0_instr, e1_instr, n_e0_instr, n_e1_instr;
    logic [ADDR_W-1:0]  e0_pc, e1_pc, n_e0_pc, n_e1_pc;
    logic               v0, v1, n_v0, n_v1;
    logic [ADDR_W-1:0]  fpc, n_fpc;
    logic               pop, push;

    assign rom_addr = fpc;
    assign ir       = e0_instr;
    assign ir_pc    = e0_pc;
    assign ir_valid = v0;

    // Next-state for the queue and the fetch PC
    always_comb begin
        n_e0_instr = e0_instr;
        n_e0_pc    = e0_pc;
        n_v0       = v0;
        n_e1_instr = e1_instr;
        n_e1_pc    = e1_pc;
        n_v1       = v1;
        n_fpc      = fpc;
        pop        = v0 && ir_ready;
        push       = !v1 || pop;

        if (redirect) begin
            // A head shown with ir_ready high is consumed and flushed with the rest
            n_e0_instr = '0;
            n_e0_pc    = '0;
            n_v0       = 1'b0;
            n_e1_instr = '0;
            n_e1_pc    = '0;
            n_v1       = 1'b0;
            n_fpc      = redirect_pc;
        end else begin
            if (pop) begin
                n_e0_instr = e1_instr;
                n_e0_pc    = e1_pc;
                n_v0       = v1;
                n_e1_instr = '0;
                n_e1_pc    = '0;
                n_v1       = 1'b0;
            end
            if (push) begin
                // Append after the pop has been applied
                if (!n_v0) begin
                    n_e0_instr = rom_data;
                    n_e0_pc    = fpc;
                    n_v0       = 1'b1;
                end else begin
                    n_e1_instr = rom_data;
                    n_e1_pc    = fpc;
                    n_v1       = 1'b1;
                end
                n_fpc = fpc + ADDR_W'(PC_STEP);
            end
        end
    end

    // Queue and fetch PC state
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            e0_instr <= '0;
            e0_pc    <= '0;
            v0       <= 1'b0;
            e1_instr <= '0;
            e1_pc    <= '0;
            v1       <= 1'b0;
            fpc      <= ADDR_W'(RESET_PC);
        end else begin
            e0_instr <= n_e0_instr;
            e0_pc    <= n_e0_pc;
            v0       <= n_v0;
            e1_instr <= n_e1_instr;
            e1_pc    <= n_e1_pc;
            v1       <= n_v1;
            fpc      <= n_fpc;
        end
    end

`ifdef FETCH_STALLCNT_EN
    // Saturating count of cycles where the head waits on downstream
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            stall_count <= 16'd0;
        end else if (ir_valid && !ir_ready && (stall_count != 16'hFFFF)) begin
            stall_count <= stall_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed self-checking bench for fetch_queue.
// Drives a combinational ROM model and checks head pc/word, valid and
// rom_addr after each edge. Define FETCH_STALLCNT_EN to also check stall_count.
module tb_fetch_queue;

    logic        clock;
    logic        resetn;
    logic [7:0]  rom_addr;
    logic [34:0] rom_data;
    logic [34:0] ir;
    logic [7:0]  ir_pc;
    logic        ir_valid;
    logic        ir_ready;
    logic        redirect;
    logic [7:0]  redirect_pc;
`ifdef FETCH_STALLCNT_EN
    logic [15:0] stall_count;
`endif

    int errors = 0;
    int checks = 0;

    fetch_queue dut (
        .clock       (clock),
        .resetn      (resetn),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .ir          (ir),
        .ir_pc       (ir_pc),
        .ir_valid    (ir_valid),
        .ir_ready    (ir_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
`ifdef FETCH_STALLCNT_EN
        ,
        .stall_count (stall_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ROM contents: distinct, address-dependent word
    function automatic logic [34:0] word(input logic [7:0] a);
        return {3'b101, 8'h5A ^ a, 16'hBEEF, a};
    endfunction

    assign rom_data = word(rom_addr);

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_head(input string tag, input logic [7:0] pc);
        check({tag, " valid"}, 64'(ir_valid), 64'd1);
        check({tag, " pc"}, 64'(ir_pc), 64'(pc));
        check({tag, " ir"}, 64'(ir), 64'(word(pc)));
    endtask

    task automatic check_empty(input string tag, input logic [7:0] addr);
        check({tag, " valid"}, 64'(ir_valid), 64'd0);
        check({tag, " ir"}, 64'(ir), 64'd0);
        check({tag, " pc"}, 64'(ir_pc), 64'd0);
        check({tag, " rom_addr"}, 64'(rom_addr), 64'(addr));
    endtask

    // Advance one edge and sample 1 time unit later
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        #1;
        check_empty("reset", 8'd0);
        step();
        resetn = 1'b1;
    endtask

    initial begin
        resetn      = 1'b1;
        ir_ready    = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 8'd0;
        #2;

        // Free run
        do_reset();
        step();
        check_head("free0", 8'd0);
        check("free0 rom_addr", 64'(rom_addr), 64'd4);
        for (int i = 1; i <= 4; i++) begin
            step();
            check_head($sformatf("free%0d", i), 8'(4 * i));
        end

        // Backpressure
        do_reset();
        ir_ready = 1'b0;
        step();
        check_head("bp first", 8'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("bp hold%0d rom_addr", i), 64'(rom_addr), 64'd8);
            check_head($sformatf("bp hold%0d", i), 8'd0);
        end
`ifdef FETCH_STALLCNT_EN
        check("stall_count", 64'(stall_count), 64'd5);
`endif
        ir_ready = 1'b1;
        #1;
        check_head("bp rel0", 8'd0);
        step();
        check_head("bp rel4", 8'd4);
        check("bp refill rom_addr", 64'(rom_addr), 64'd12);
        step();
        check_head("bp rel8", 8'd8);
        step();
        check_head("bp rel12", 8'd12);
`ifdef FETCH_STALLCNT_EN
        check("stall_count after", 64'(stall_count), 64'd5);
`endif

        // Jump to 4 while full, then loop 4 -> 8 -> redirect 4
        redirect    = 1'b1;
        redirect_pc = 8'd4;
        step();
        redirect = 1'b0;
        check_empty("jump bubble", 8'd4);
        step();
        check_head("jump t4", 8'd4);
        step();
        check_head("jump t8", 8'd8);
        redirect = 1'b1;
        step();
        redirect = 1'b0;
        check_empty("loop bubble", 8'd4);
        step();
        check_head("loop t4", 8'd4);
        step();
        check_head("loop t8", 8'd8);

        // Back-to-back redirects: last wins
        redirect    = 1'b1;
        redirect_pc = 8'd100;
        step();
        check_empty("b2b first", 8'd100);
        redirect_pc = 8'd200;
        step();
        redirect = 1'b0;
        check_empty("b2b second", 8'd200);
        step();
        check_head("b2b target", 8'd200);

        // Wrap at 252
        redirect    = 1'b1;
        redirect_pc = 8'd252;
        step();
        redirect = 1'b0;
        check_empty("wrap bubble", 8'd252);
        step();
        check_head("wrap 252", 8'd252);
        check("wrap rom_addr", 64'(rom_addr), 64'd0);
        step();
        check_head("wrap 0", 8'd0);

        // Reset mid-run with two queued
        ir_ready = 1'b0;
        step();
        check("mid full rom_addr", 64'(rom_addr), 64'd8);
        #2;
        resetn = 1'b0;
        #1;
        check_empty("mid reset", 8'd0);
`ifdef FETCH_STALLCNT_EN
        check("mid reset stall_count", 64'(stall_count), 64'd0);
`endif
        step();
        resetn   = 1'b1;
        ir_ready = 1'b1;
        step();
        check_head("after reset", 8'd0);
        check("after reset rom_addr", 64'(rom_addr), 64'd4);

        // Full queue, pop and push requested together with redirect
        ir_ready = 1'b0;
        step();
        check_head("full head", 8'd0);
        check("full rom_addr", 64'(rom_addr), 64'd8);
        ir_ready    = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 8'd40;
        step();
        redirect = 1'b0;
        check_empty("full redirect", 8'd40);
        step();
        check_head("full redirect target", 8'd40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
